// File: rtl/stage_mem_pkg.sv
// Shared definitions for the memory-access stage: funct3 codes, byte-enable
// patterns, FSM encoding and the load/store legality check.
package stage_mem_pkg;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

  localparam logic [2:0] F3_SB  = 3'b000;
  localparam logic [2:0] F3_SH  = 3'b001;
  localparam logic [2:0] F3_SW  = 3'b010;

  localparam logic [3:0] BE_BYTE = 4'b0001;
  localparam logic [3:0] BE_HALF = 4'b0011;
  localparam logic [3:0] BE_WORD = 4'b1111;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } mem_state_t;

  function automatic logic f3_legal(input logic is_load, input logic [2:0] f3);
    if (is_load)
      return (f3 == F3_LB) || (f3 == F3_LH) || (f3 == F3_LW) ||
             (f3 == F3_LBU) || (f3 == F3_LHU);
    else
      return (f3 == F3_SB) || (f3 == F3_SH) || (f3 == F3_SW);
  endfunction

endpackage

// File: rtl/stage_mem_if.sv
// Data-memory request/ready bus between the MEM stage (master) and memory.
interface stage_mem_if #(
  parameter int ADDR_WIDTH = 32
) ();
  logic                  req;
  logic                  we;
  logic [ADDR_WIDTH-1:0] addr;
  logic [31:0]           wdata;
  logic [3:0]            be;
  logic                  ready;
  logic [31:0]           rdata;

  modport master (output req, we, addr, wdata, be, input ready, rdata);
  modport slave  (input req, we, addr, wdata, be, output ready, rdata);
endinterface

// File: rtl/stage_mem_load_store_align.sv
// Combinational lane steering: store replication and byte enables, access
// legality, and shift/extend of the raw read word.
module stage_mem_load_store_align
  import stage_mem_pkg::*;
(
  input  logic [1:0]  i_addr_lo,
  input  logic [2:0]  i_funct3,
  input  logic        i_memread,
  input  logic        i_memwrite,
  input  logic [31:0] i_store_data,
  input  logic [31:0] i_rdata,
  output logic [31:0] o_wdata,
  output logic [3:0]  o_be,
  output logic        o_misaligned,
  output logic [31:0] o_load_data
);

  logic [31:0] w_shifted;

  assign w_shifted = i_rdata >> {i_addr_lo, 3'b000};

  always_comb begin
    o_wdata      = 32'h0;
    o_be         = 4'h0;
    o_misaligned = 1'b0;
    case (i_funct3[1:0])
      2'b00: begin
        o_wdata = {4{i_store_data[7:0]}};
        o_be    = BE_BYTE << i_addr_lo;
      end
      2'b01: begin
        o_wdata = {2{i_store_data[15:0]}};
        o_be    = BE_HALF << i_addr_lo;
      end
      default: begin
        o_wdata = i_store_data;
        o_be    = BE_WORD;
      end
    endcase
    if (!i_memwrite)
      o_wdata = 32'h0;
    // Illegal encodings share the misaligned path so they retire without a bus access
    if (i_memread && i_memwrite)
      o_misaligned = 1'b1;
    else if (i_memread || i_memwrite) begin
      if (!f3_legal(i_memread, i_funct3))
        o_misaligned = 1'b1;
      else if ((i_funct3[1:0] == 2'b01) && i_addr_lo[0])
        o_misaligned = 1'b1;
      else if ((i_funct3[1:0] == 2'b10) && (i_addr_lo != 2'b00))
        o_misaligned = 1'b1;
    end
  end

  always_comb begin
    case (i_funct3)
      F3_LB:   o_load_data = {{24{w_shifted[7]}}, w_shifted[7:0]};
      F3_LH:   o_load_data = {{16{w_shifted[15]}}, w_shifted[15:0]};
      F3_LBU:  o_load_data = {24'h0, w_shifted[7:0]};
      F3_LHU:  o_load_data = {16'h0, w_shifted[15:0]};
      default: o_load_data = w_shifted;
    endcase
  end

endmodule

// File: rtl/stage_mem.sv
// MEM pipeline stage: runs one data-bus transaction per load/store, stalls the
// front of the pipe while busy, and owns the MEM/WB register.
//   state | meaning
//   IDLE  | retire non-memory ops in one cycle, issue aligned loads/stores
//   BUSY  | dmem_req held, waiting for ready or timeout
//   DONE  | MEM/WB loads captured result, pipeline released
module stage_mem
  import stage_mem_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 16,
  parameter int ADDR_WIDTH     = 32
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_ex_mem_valid,
  input  logic [31:0] i_ex_mem_alu_result,
  input  logic [31:0] i_ex_mem_write_data,
  input  logic [2:0]  i_ex_mem_funct3,
  input  logic        i_ex_mem_memread,
  input  logic        i_ex_mem_memwrite,
  input  logic        i_ex_mem_regwrite,
  input  logic        i_ex_mem_memtoreg,
  input  logic [4:0]  i_ex_mem_rd,
  stage_mem_if.master bus,
  output logic        o_mem_stall,
  output logic        o_mem_misaligned,
  output logic        o_mem_bus_error,
  output logic        o_mem_wb_valid,
  output logic        o_mem_wb_regwrite,
  output logic        o_mem_wb_memtoreg,
  output logic [4:0]  o_mem_wb_rd,
  output logic [31:0] o_mem_wb_alu_result,
  output logic [31:0] o_mem_wb_read_data
);

  localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  mem_state_t            r_state;
  logic [CNT_W-1:0]      r_cnt;
  logic                  r_req;
  logic                  r_we;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [31:0]           r_wdata;
  logic [3:0]            r_be;
  logic [31:0]           r_load_data;
  logic                  r_misaligned;
  logic                  r_bus_error;
  logic                  r_wb_valid;
  logic                  r_wb_regwrite;
  logic                  r_wb_memtoreg;
  logic [4:0]            r_wb_rd;
  logic [31:0]           r_wb_alu_result;
  logic [31:0]           r_wb_read_data;

  logic [31:0] w_wdata;
  logic [3:0]  w_be;
  logic        w_misaligned;
  logic [31:0] w_load_data;
  logic        w_mem_op;
  logic        w_issue;
  logic        w_bad;

  stage_mem_load_store_align u_align (
    .i_addr_lo    (i_ex_mem_alu_result[1:0]),
    .i_funct3     (i_ex_mem_funct3),
    .i_memread    (i_ex_mem_memread),
    .i_memwrite   (i_ex_mem_memwrite),
    .i_store_data (i_ex_mem_write_data),
    .i_rdata      (bus.rdata),
    .o_wdata      (w_wdata),
    .o_be         (w_be),
    .o_misaligned (w_misaligned),
    .o_load_data  (w_load_data)
  );

  assign w_mem_op = i_ex_mem_valid && (i_ex_mem_memread || i_ex_mem_memwrite);
  assign w_issue  = w_mem_op && !w_misaligned;
  assign w_bad    = w_mem_op && w_misaligned;

  // Stall rises in the issue cycle itself so EX/MEM holds the op for BUSY/DONE
  assign o_mem_stall = ((r_state == ST_IDLE) && w_issue) || (r_state == ST_BUSY);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state         <= ST_IDLE;
      r_cnt           <= '0;
      r_req           <= 1'b0;
      r_we            <= 1'b0;
      r_addr          <= '0;
      r_wdata         <= '0;
      r_be            <= '0;
      r_load_data     <= '0;
      r_misaligned    <= 1'b0;
      r_bus_error     <= 1'b0;
      r_wb_valid      <= 1'b0;
      r_wb_regwrite   <= 1'b0;
      r_wb_memtoreg   <= 1'b0;
      r_wb_rd         <= '0;
      r_wb_alu_result <= '0;
      r_wb_read_data  <= '0;
    end else begin
      r_misaligned <= 1'b0;
      r_bus_error  <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_issue) begin
            r_state       <= ST_BUSY;
            r_req         <= 1'b1;
            r_we          <= i_ex_mem_memwrite;
            r_addr        <= ADDR_WIDTH'({i_ex_mem_alu_result[31:2], 2'b00});
            r_wdata       <= w_wdata;
            r_be          <= w_be;
            r_cnt         <= '0;
            r_wb_valid    <= 1'b0;
            r_wb_regwrite <= 1'b0;
          end else begin
            r_wb_valid      <= i_ex_mem_valid;
            r_wb_regwrite   <= i_ex_mem_valid && i_ex_mem_regwrite && !w_bad;
            r_wb_memtoreg   <= i_ex_mem_memtoreg;
            r_wb_rd         <= i_ex_mem_rd;
            r_wb_alu_result <= i_ex_mem_alu_result;
            r_wb_read_data  <= '0;
            r_misaligned    <= w_bad;
          end
        end
        ST_BUSY: begin
          r_cnt <= r_cnt + 1'b1;
          if (bus.ready) begin
            r_load_data <= w_load_data;
            r_req       <= 1'b0;
            r_state     <= ST_DONE;
          end else if (r_cnt == CNT_LAST) begin
            r_load_data <= '0;
            r_req       <= 1'b0;
            r_bus_error <= 1'b1;
            r_state     <= ST_DONE;
          end
        end
        ST_DONE: begin
          // r_bus_error still holds the timeout pulse here
          r_wb_valid      <= 1'b1;
          r_wb_regwrite   <= i_ex_mem_regwrite && !r_bus_error;
          r_wb_memtoreg   <= i_ex_mem_memtoreg;
          r_wb_rd         <= i_ex_mem_rd;
          r_wb_alu_result <= i_ex_mem_alu_result;
          r_wb_read_data  <= r_load_data;
          r_state         <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign bus.req   = r_req;
  assign bus.we    = r_we;
  assign bus.addr  = r_addr;
  assign bus.wdata = r_wdata;
  assign bus.be    = r_be;

  assign o_mem_misaligned    = r_misaligned;
  assign o_mem_bus_error     = r_bus_error;
  assign o_mem_wb_valid      = r_wb_valid;
  assign o_mem_wb_regwrite   = r_wb_regwrite;
  assign o_mem_wb_memtoreg   = r_wb_memtoreg;
  assign o_mem_wb_rd         = r_wb_rd;
  assign o_mem_wb_alu_result = r_wb_alu_result;
  assign o_mem_wb_read_data  = r_wb_read_data;

endmodule

// File: tb/tb_stage_mem.sv
// Directed bench for stage_mem: expected MEM/WB results are queued at issue
// and popped when the stage retires the instruction.
module tb_stage_mem;
  import stage_mem_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic        ex_valid, ex_memread, ex_memwrite, ex_regwrite, ex_memtoreg;
  logic [31:0] ex_alu, ex_wdata;
  logic [2:0]  ex_f3;
  logic [4:0]  ex_rd;
  logic        mem_stall, mem_mis, mem_err;
  logic        wb_valid, wb_regwrite, wb_memtoreg;
  logic [4:0]  wb_rd;
  logic [31:0] wb_alu, wb_rdata;

  stage_mem_if #(.ADDR_WIDTH(32)) bus ();

  stage_mem #(.TIMEOUT_CYCLES(16), .ADDR_WIDTH(32)) dut (
    .clk                 (clk),
    .rst_n               (rst_n),
    .i_ex_mem_valid      (ex_valid),
    .i_ex_mem_alu_result (ex_alu),
    .i_ex_mem_write_data (ex_wdata),
    .i_ex_mem_funct3     (ex_f3),
    .i_ex_mem_memread    (ex_memread),
    .i_ex_mem_memwrite   (ex_memwrite),
    .i_ex_mem_regwrite   (ex_regwrite),
    .i_ex_mem_memtoreg   (ex_memtoreg),
    .i_ex_mem_rd         (ex_rd),
    .bus                 (bus),
    .o_mem_stall         (mem_stall),
    .o_mem_misaligned    (mem_mis),
    .o_mem_bus_error     (mem_err),
    .o_mem_wb_valid      (wb_valid),
    .o_mem_wb_regwrite   (wb_regwrite),
    .o_mem_wb_memtoreg   (wb_memtoreg),
    .o_mem_wb_rd         (wb_rd),
    .o_mem_wb_alu_result (wb_alu),
    .o_mem_wb_read_data  (wb_rdata)
  );

  typedef struct {
    logic        regwrite;
    logic        memtoreg;
    logic [4:0]  rd;
    logic [31:0] alu;
    logic [31:0] rdata;
  } wb_t;

  wb_t sbq[$];
  int  total = 0;
  int  bad   = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    ex_valid = 1'b0; ex_memread = 1'b0; ex_memwrite = 1'b0;
    ex_regwrite = 1'b0; ex_memtoreg = 1'b0;
    ex_alu = 32'h0; ex_wdata = 32'h0; ex_f3 = 3'b000; ex_rd = 5'd0;
  endtask

  task automatic drive(input logic rd_op, input logic wr_op, input logic [2:0] f3,
                       input logic [31:0] addr, input logic [31:0] d,
                       input logic [4:0] rd, input logic regwr);
    ex_valid = 1'b1; ex_memread = rd_op; ex_memwrite = wr_op;
    ex_regwrite = regwr; ex_memtoreg = rd_op;
    ex_alu = addr; ex_wdata = d; ex_f3 = f3; ex_rd = rd;
  endtask

  task automatic push(input logic regwr, input logic m2r, input logic [4:0] rd,
                      input logic [31:0] alu, input logic [31:0] rdata);
    wb_t e;
    e.regwrite = regwr; e.memtoreg = m2r; e.rd = rd; e.alu = alu; e.rdata = rdata;
    sbq.push_back(e);
  endtask

  task automatic retire(input string tag);
    wb_t e;
    chk({tag, "_wb_valid"}, 32'(wb_valid), 32'd1);
    chk({tag, "_sb_nonempty"}, 32'(sbq.size() > 0), 32'd1);
    if (sbq.size() > 0) begin
      e = sbq.pop_front();
      chk({tag, "_wb_regwrite"}, 32'(wb_regwrite), 32'(e.regwrite));
      chk({tag, "_wb_memtoreg"}, 32'(wb_memtoreg), 32'(e.memtoreg));
      chk({tag, "_wb_rd"}, 32'(wb_rd), 32'(e.rd));
      chk({tag, "_wb_alu"}, wb_alu, e.alu);
      chk({tag, "_wb_rdata"}, wb_rdata, e.rdata);
    end
  endtask

  // Entered with the op driven and #1 settled; leaves after retirement with inputs idle
  task automatic run_mem(input string tag, input int waits, input logic [31:0] rword,
                         input logic [31:0] e_addr, input logic e_we,
                         input logic [3:0] e_be, input logic [31:0] e_wdata);
    int stalls;
    stalls = 0;
    if (mem_stall) stalls++;
    tick();
    chk({tag, "_req"}, 32'(bus.req), 32'd1);
    chk({tag, "_addr"}, bus.addr, e_addr);
    chk({tag, "_we"}, 32'(bus.we), 32'(e_we));
    chk({tag, "_be"}, 32'(bus.be), 32'(e_be));
    if (e_we) chk({tag, "_wdata"}, bus.wdata, e_wdata);
    chk({tag, "_bubble"}, 32'(wb_valid), 32'd0);
    for (int k = 0; k < waits; k++) begin
      if (mem_stall) stalls++;
      tick();
    end
    bus.ready = 1'b1;
    bus.rdata = rword;
    #1;
    if (mem_stall) stalls++;
    tick();
    bus.ready = 1'b0;
    bus.rdata = 32'h0;
    chk({tag, "_stall_cycles"}, 32'(stalls), 32'(waits + 2));
    chk({tag, "_done_stall"}, 32'(mem_stall), 32'd0);
    chk({tag, "_done_req"}, 32'(bus.req), 32'd0);
    tick();
    idle_inputs();
    retire(tag);
  endtask

  task automatic run_bad(input string tag);
    #1;
    chk({tag, "_stall"}, 32'(mem_stall), 32'd0);
    tick();
    idle_inputs();
    chk({tag, "_mis"}, 32'(mem_mis), 32'd1);
    chk({tag, "_req"}, 32'(bus.req), 32'd0);
    retire(tag);
    tick();
    chk({tag, "_mis_pulse"}, 32'(mem_mis), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired before completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int busy;
    idle_inputs();
    bus.ready = 1'b0;
    bus.rdata = 32'h0;
    tick();
    tick();
    chk("rst_req", 32'(bus.req), 32'd0);
    chk("rst_stall", 32'(mem_stall), 32'd0);
    chk("rst_wb_valid", 32'(wb_valid), 32'd0);
    chk("rst_wb_alu", wb_alu, 32'd0);
    rst_n = 1'b1;
    tick();

    drive(1'b0, 1'b0, 3'b000, 32'h0000_0042, 32'h0, 5'd5, 1'b1);
    push(1'b1, 1'b0, 5'd5, 32'h42, 32'h0);
    #1;
    chk("add_stall", 32'(mem_stall), 32'd0);
    tick();
    idle_inputs();
    chk("add_req", 32'(bus.req), 32'd0);
    retire("add");

    drive(1'b0, 1'b1, F3_SW, 32'h100, 32'hDEAD_BEEF, 5'd0, 1'b0);
    push(1'b0, 1'b0, 5'd0, 32'h100, 32'h0);
    #1;
    run_mem("sw", 2, 32'h0, 32'h100, 1'b1, 4'b1111, 32'hDEAD_BEEF);

    drive(1'b0, 1'b1, F3_SH, 32'h102, 32'h1234_ABCD, 5'd0, 1'b0);
    push(1'b0, 1'b0, 5'd0, 32'h102, 32'h0);
    #1;
    run_mem("sh", 1, 32'h0, 32'h100, 1'b1, 4'b1100, 32'hABCD_ABCD);

    drive(1'b0, 1'b1, F3_SB, 32'h101, 32'h0000_0055, 5'd0, 1'b0);
    push(1'b0, 1'b0, 5'd0, 32'h101, 32'h0);
    #1;
    run_mem("sb", 0, 32'h0, 32'h100, 1'b1, 4'b0010, 32'h5555_5555);

    drive(1'b1, 1'b0, F3_LB, 32'h103, 32'h0, 5'd7, 1'b1);
    push(1'b1, 1'b1, 5'd7, 32'h103, 32'hFFFF_FF80);
    #1;
    run_mem("lb", 1, 32'h80FF_0000, 32'h100, 1'b0, 4'b1000, 32'h0);

    drive(1'b1, 1'b0, F3_LBU, 32'h103, 32'h0, 5'd8, 1'b1);
    push(1'b1, 1'b1, 5'd8, 32'h103, 32'h0000_0080);
    #1;
    run_mem("lbu", 0, 32'h80FF_0000, 32'h100, 1'b0, 4'b1000, 32'h0);

    drive(1'b1, 1'b0, F3_LHU, 32'h102, 32'h0, 5'd9, 1'b1);
    push(1'b1, 1'b1, 5'd9, 32'h102, 32'h0000_80FF);
    #1;
    run_mem("lhu", 2, 32'h80FF_0000, 32'h100, 1'b0, 4'b1100, 32'h0);

    drive(1'b1, 1'b0, F3_LH, 32'h100, 32'h0, 5'd10, 1'b1);
    push(1'b1, 1'b1, 5'd10, 32'h100, 32'hFFFF_8001);
    #1;
    run_mem("lh", 0, 32'h0000_8001, 32'h100, 1'b0, 4'b0011, 32'h0);

    drive(1'b1, 1'b0, F3_LW, 32'h104, 32'h0, 5'd11, 1'b1);
    push(1'b1, 1'b1, 5'd11, 32'h104, 32'h1234_5678);
    #1;
    run_mem("lw", 0, 32'h1234_5678, 32'h104, 1'b0, 4'b1111, 32'h0);

    drive(1'b1, 1'b0, F3_LW, 32'h102, 32'h0, 5'd6, 1'b1);
    push(1'b0, 1'b1, 5'd6, 32'h102, 32'h0);
    run_bad("lw_mis");

    drive(1'b0, 1'b1, F3_SH, 32'h101, 32'h1111_2222, 5'd0, 1'b0);
    push(1'b0, 1'b0, 5'd0, 32'h101, 32'h0);
    run_bad("sh_mis");

    drive(1'b1, 1'b0, 3'b011, 32'h100, 32'h0, 5'd3, 1'b1);
    push(1'b0, 1'b1, 5'd3, 32'h100, 32'h0);
    run_bad("ld_f3_illegal");

    drive(1'b1, 1'b1, F3_LW, 32'h100, 32'h0, 5'd4, 1'b1);
    push(1'b0, 1'b1, 5'd4, 32'h100, 32'h0);
    run_bad("rd_wr_both");

    drive(1'b1, 1'b0, F3_LW, 32'h200, 32'h0, 5'd12, 1'b1);
    push(1'b0, 1'b1, 5'd12, 32'h200, 32'h0);
    #1;
    tick();
    busy = 0;
    while (bus.req === 1'b1 && busy < 40) begin
      busy++;
      chk("to_no_early_err", 32'(mem_err), 32'd0);
      tick();
    end
    chk("to_busy_cycles", 32'(busy), 32'd16);
    chk("to_err_pulse", 32'(mem_err), 32'd1);
    chk("to_req_drop", 32'(bus.req), 32'd0);
    chk("to_stall", 32'(mem_stall), 32'd0);
    tick();
    idle_inputs();
    chk("to_err_clear", 32'(mem_err), 32'd0);
    retire("to");

    drive(1'b0, 1'b1, F3_SW, 32'h300, 32'hCAFE_F00D, 5'd0, 1'b0);
    #1;
    tick();
    chk("rstb_req_busy", 32'(bus.req), 32'd1);
    #1;
    rst_n = 1'b0;
    #1;
    idle_inputs();
    bus.ready = 1'b1;
    #1;
    chk("rstb_req", 32'(bus.req), 32'd0);
    chk("rstb_stall", 32'(mem_stall), 32'd0);
    chk("rstb_addr", bus.addr, 32'h0);
    chk("rstb_be", 32'(bus.be), 32'd0);
    chk("rstb_wdata", bus.wdata, 32'h0);
    chk("rstb_we", 32'(bus.we), 32'd0);
    chk("rstb_wb_alu", wb_alu, 32'h0);
    chk("rstb_wb_valid", 32'(wb_valid), 32'd0);
    tick();
    rst_n = 1'b1;
    tick();
    bus.ready = 1'b0;
    chk("rstb_late_ready_req", 32'(bus.req), 32'd0);
    chk("rstb_late_ready_wb", 32'(wb_valid), 32'd0);
    chk("rstb_late_ready_err", 32'(mem_err), 32'd0);

    chk("sb_drained", 32'(sbq.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
